// File: rtl/instr_decode_exec_if.sv
//------------------------------------------------------------------------------
// Module      : instr_decode_exec_if
// Description : Instruction handshake bundle between the fetch stage and
//               instr_decode_exec (valid / 32-bit word / ready).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_decode_exec_if;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;

    modport master (
        output instr_valid,
        output instruction,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instruction,
        output instr_ready
    );
endinterface

`default_nettype wire

// File: rtl/instr_decode_exec.sv
//------------------------------------------------------------------------------
// Module      : instr_decode_exec
// Description : Decodes pedometer instructions, holds an 8x8 weight file and
//               runs weighted step detection with hysteresis on (A,B) samples.
//               Optional macro STEP_SAT_EN: step_count saturates instead of wrapping.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_decode_exec #(
    parameter int STEP_W = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    instr_decode_exec_if.slave     bus,
    input  wire logic [2:0]        rd_addr,
    output logic [7:0]             rd_data,
    output logic [STEP_W-1:0]      step_count,
    output logic                   step_pulse,
    output logic                   illegal_op,
    output logic                   busy
);

    localparam logic [3:0]        c_OP_CLR   = 4'b0010;
    localparam logic [3:0]        c_OP_WR1   = 4'b0110;
    localparam logic [3:0]        c_OP_WR2   = 4'b1010;
    localparam logic [3:0]        c_OP_CNT   = 4'b1100;
    localparam logic [STEP_W-1:0] c_STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC_A = 2'd1,
        S_MAC_B = 2'd2,
        S_CMP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_weight [8];
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [16:0]       r_acc;
    logic              r_above;
    logic [STEP_W-1:0] r_step_count;
    logic              r_step_pulse;
    logic              r_illegal;

    logic              w_accept;
    logic [3:0]        w_opcode;
    logic [2:0]        w_addr1;
    logic [7:0]        w_data1;
    logic [2:0]        w_addr2;
    logic [7:0]        w_data2;
    logic [7:0]        w_mul_w;
    logic [7:0]        w_mul_x;
    logic [15:0]       w_prod;
    logic [15:0]       w_thr;
    logic              w_hit;
    logic [STEP_W-1:0] w_count_inc;
    logic              w_unused_bits;

    // Field extraction; the word only matters on the accept edge.
    assign w_opcode      = bus.instruction[3:0];
    assign w_addr1       = bus.instruction[6:4];
    assign w_data1       = bus.instruction[14:7];
    assign w_addr2       = bus.instruction[17:15];
    assign w_data2       = bus.instruction[25:18];
    assign w_unused_bits = ^bus.instruction[31:26];

    assign bus.instr_ready = (r_state == S_IDLE) && !reset;
    assign w_accept        = bus.instr_valid && bus.instr_ready;

    // One shared multiplier: w0*A in MAC_A, w1*B in MAC_B.
    assign w_mul_w = (r_state == S_MAC_B) ? r_weight[1] : r_weight[0];
    assign w_mul_x = (r_state == S_MAC_B) ? r_b : r_a;
    assign w_prod  = {8'd0, w_mul_w} * {8'd0, w_mul_x};

    assign w_thr = {r_weight[2], r_weight[3]};
    assign w_hit = (r_acc > {1'b0, w_thr});

    always_comb begin
        w_count_inc = r_step_count + c_STEP_ONE;
`ifdef STEP_SAT_EN
        if (&r_step_count) begin
            w_count_inc = r_step_count;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_opcode == c_OP_CNT)) begin
                    w_state_nxt = S_MAC_A;
                end
            end
            S_MAC_A: w_state_nxt = S_MAC_B;
            S_MAC_B: w_state_nxt = S_CMP;
            S_CMP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < 8; i++) begin
                r_weight[i] <= 8'd0;
            end
            r_a          <= 8'd0;
            r_b          <= 8'd0;
            r_acc        <= 17'd0;
            r_above      <= 1'b0;
            r_step_count <= '0;
            r_step_pulse <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_step_pulse <= 1'b0;
            r_illegal    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_opcode)
                            c_OP_CLR: begin
                                for (int i = 0; i < 8; i++) begin
                                    r_weight[i] <= 8'd0;
                                end
                            end
                            c_OP_WR1: r_weight[w_addr1] <= w_data1;
                            c_OP_WR2: begin
                                // Second write is later in program order, so Data2 wins on equal addresses.
                                r_weight[w_addr1] <= w_data1;
                                r_weight[w_addr2] <= w_data2;
                            end
                            c_OP_CNT: begin
                                r_a <= bus.instruction[11:4];
                                r_b <= bus.instruction[19:12];
                            end
                            default: r_illegal <= 1'b1;
                        endcase
                    end
                end
                S_MAC_A: r_acc <= {1'b0, w_prod};
                S_MAC_B: r_acc <= r_acc + {1'b0, w_prod};
                S_CMP: begin
                    if (w_hit && !r_above) begin
                        r_step_count <= w_count_inc;
                        r_step_pulse <= 1'b1;
                    end
                    r_above <= w_hit;
                end
                default: ;
            endcase
        end
    end

    assign rd_data    = r_weight[rd_addr];
    assign step_count = r_step_count;
    assign step_pulse = r_step_pulse;
    assign illegal_op = r_illegal;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_exec.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_decode_exec
// Description : Directed self-checking bench for instr_decode_exec (STEP_W=16
//               instance plus a STEP_W=4 instance for wrap/saturation).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_decode_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rd_addr0, rd_addr1;
    logic [7:0]  rd_data0, rd_data1;
    logic [15:0] step_count0;
    logic [3:0]  step_count1;
    logic        step_pulse0, step_pulse1;
    logic        illegal_op0, illegal_op1;
    logic        busy0, busy1;

    int n_total = 0;
    int n_bad   = 0;
    int n_acc0  = 0;

    localparam logic [31:0] c_CNT_HI = 32'h0001E64C;  // A=100, B=30 -> 290
    localparam logic [31:0] c_CNT_LO = {12'd0, 8'd10, 8'd10, 4'b1100};  // score 50

    instr_decode_exec_if if0 ();
    instr_decode_exec_if if1 ();

    instr_decode_exec #(.STEP_W(16)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .bus        (if0.slave),
        .rd_addr    (rd_addr0),
        .rd_data    (rd_data0),
        .step_count (step_count0),
        .step_pulse (step_pulse0),
        .illegal_op (illegal_op0),
        .busy       (busy0)
    );

    instr_decode_exec #(.STEP_W(4)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .bus        (if1.slave),
        .rd_addr    (rd_addr1),
        .rd_data    (rd_data1),
        .step_count (step_count1),
        .step_pulse (step_pulse1),
        .illegal_op (illegal_op1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (if0.instr_valid && if0.instr_ready) n_acc0++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_wr2(input logic [2:0] a1, input logic [7:0] d1,
                                           input logic [2:0] a2, input logic [7:0] d2);
        return {6'd0, d2, a2, d1, a1, 4'b1010};
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? if1.instr_ready : if0.instr_ready;
    endfunction

    function automatic logic [31:0] cnt_of(input bit sel);
        return sel ? {28'd0, step_count1} : {16'd0, step_count0};
    endfunction

    function automatic logic pulse_of(input bit sel);
        return sel ? step_pulse1 : step_pulse0;
    endfunction

    // Returns on the falling edge just after the accept edge.
    task automatic send(input bit sel, input logic [31:0] ins);
        int k = 0;
        @(negedge clk);
        if (sel) begin if1.instr_valid = 1'b1; if1.instruction = ins; end
        else     begin if0.instr_valid = 1'b1; if0.instruction = ins; end
        while (!rdy(sel) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        if (sel) if1.instr_valid = 1'b0;
        else     if0.instr_valid = 1'b0;
    endtask

    task automatic run_cnt(input bit sel, input logic [31:0] ins, input int exp_pulse,
                           input logic [31:0] exp_cnt, input string tag);
        int n_low = 0;
        int n_pulse = 0;
        send(sel, ins);
        for (int i = 0; i < 6; i++) begin
            if (!rdy(sel)) n_low++;
            if (pulse_of(sel)) n_pulse++;
            @(negedge clk);
        end
        check({tag, "_ready_low"}, n_low, 3);
        check({tag, "_pulses"}, n_pulse, exp_pulse);
        check({tag, "_count"}, cnt_of(sel), exp_cnt);
    endtask

    task automatic chk_rd(input logic [2:0] addr, input logic [7:0] exp, input string tag);
        rd_addr0 = addr;
        #1;
        check(tag, {24'd0, rd_data0}, {24'd0, exp});
    endtask

    initial begin
        logic [31:0] exp_wrap;
        reset = 1'b1;
        rd_addr0 = 3'd0;
        rd_addr1 = 3'd0;
        if0.instr_valid = 1'b0; if0.instruction = 32'd0;
        if1.instr_valid = 1'b0; if1.instruction = 32'd0;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", {31'd0, if0.instr_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, if0.instr_ready}, 32'd1);
        check("count_reset", {16'd0, step_count0}, 32'd0);
        check("busy_reset", {31'd0, busy0}, 32'd0);
        check("pulse_reset", {30'd0, step_pulse0, illegal_op0}, 32'd0);
        for (int a = 0; a < 8; a++) chk_rd(a[2:0], 8'd0, "rd_reset");

        // Weight writes
        send(0, 32'h000C810A);
        send(0, 32'h000180AA);
        chk_rd(3'd0, 8'd2, "w0");
        chk_rd(3'd1, 8'd3, "w1");
        chk_rd(3'd2, 8'd1, "w2");
        chk_rd(3'd3, 8'd0, "w3");
        send(0, mk_wr2(3'd5, 8'h11, 3'd5, 8'h22));
        chk_rd(3'd5, 8'h22, "wr2_same_addr");
        send(0, {17'd0, 8'h44, 3'd6, 4'b0110});
        chk_rd(3'd6, 8'h44, "wr1_w6");

        // Step detection and hysteresis
        run_cnt(0, c_CNT_HI, 1, 32'd1, "cnt_hit");
        run_cnt(0, c_CNT_HI, 0, 32'd1, "cnt_hold_above");
        run_cnt(0, c_CNT_LO, 0, 32'd1, "cnt_below");
        run_cnt(0, c_CNT_HI, 1, 32'd2, "cnt_recross");

        // Illegal opcodes
        send(0, 32'h00000005);
        check("illegal5_pulse", {31'd0, illegal_op0}, 32'd1);
        @(negedge clk);
        check("illegal5_clear", {31'd0, illegal_op0}, 32'd0);
        send(0, 32'h00000000);
        check("illegal0_pulse", {31'd0, illegal_op0}, 32'd1);
        check("illegal0_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk);
        check("illegal0_clear", {31'd0, illegal_op0}, 32'd0);
        check("illegal_count", {16'd0, step_count0}, 32'd2);
        chk_rd(3'd0, 8'd2, "illegal_w0");
        chk_rd(3'd5, 8'h22, "illegal_w5");

        // Valid held through busy window with a changing word
        n_acc0 = 0;
        @(negedge clk);
        if0.instr_valid = 1'b1;
        if0.instruction = c_CNT_LO;
        @(negedge clk);
        if0.instruction = {17'd0, 8'h77, 3'd0, 4'b0110};
        @(negedge clk);
        @(negedge clk);
        if0.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_accepts", n_acc0, 1);
        chk_rd(3'd0, 8'd2, "busy_w0_unchanged");
        check("busy_count", {16'd0, step_count0}, 32'd2);

        // Reset during MAC_B of a hitting CNT
        send(0, c_CNT_HI);
        @(negedge clk);
        check("midrst_in_macb", {31'd0, busy0}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_count", {16'd0, step_count0}, 32'd0);
        check("midrst_idle", {31'd0, busy0}, 32'd0);
        check("midrst_ready", {31'd0, if0.instr_ready}, 32'd1);
        begin
            int n_p = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (step_pulse0) n_p++;
            end
            check("midrst_no_pulse", n_p, 0);
        end
        chk_rd(3'd0, 8'd0, "midrst_w0");

        // CLR leaves the count alone
        send(0, 32'h000C810A);
        send(0, 32'h000180AA);
        run_cnt(0, c_CNT_HI, 1, 32'd1, "cnt_after_rst");
        send(0, 32'h00000002);
        for (int a = 0; a < 4; a++) chk_rd(a[2:0], 8'd0, "clr_w");
        chk_rd(3'd5, 8'd0, "clr_w5");
        check("clr_count", {16'd0, step_count0}, 32'd1);

        // STEP_W=4 instance: wrap or saturate after 16 crossings
        send(1, 32'h000C810A);
        send(1, 32'h000180AA);
        for (int i = 1; i <= 16; i++) begin
`ifdef STEP_SAT_EN
            exp_wrap = (i > 15) ? 32'd15 : i;
`else
            exp_wrap = i % 16;
`endif
            run_cnt(1, c_CNT_HI, 1, exp_wrap, "w4_hi");
            run_cnt(1, c_CNT_LO, 0, exp_wrap, "w4_lo");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
